// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the Gambling_CPU
// (data memory, register file and ALU).
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : cpu_pkg

// File: rtl/data_memory_if.sv
// Load/store port between the execute stage (master) and the data memory (slave).
// There is no handshake: the memory accepts one access every cycle.
interface data_memory_if;
  import cpu_pkg::*;

  logic  we;
  addr_t a;
  word_t wd;
  word_t rd;

  modport master (
    output we,
    output a,
    output wd,
    input  rd
  );

  modport slave (
    input  we,
    input  a,
    input  wd,
    output rd
  );

endinterface : data_memory_if

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous full-word writes, combinational reads.
// The byte address is reduced to a word index; the two low bits and all high bits alias.
module data_memory #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign idx = bus.a[IDX_W+1:2];

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.a[ADDR_W-1:IDX_W+2], bus.a[1:0]};

  // NOTE: the array is built from flops rather than a RAM macro so that the
  // asynchronous reset can clear every word; a RAM block could not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we) begin
      // NOTE: non-blocking so the combinational read sees the old word until
      // the edge has fully resolved.
      mem[idx] <= bus.wd;
    end
  end

  assign bus.rd = mem[idx];

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset clearing, write/read, write disable,
// aliasing, reset priority and back-to-back writes.
`timescale 1ns/100ps
module tb_data_memory;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  data_memory_if bus ();

  data_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs and sample rd 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.we = 1'b0;
    bus.wd = '0;
    bus.a  = 32'h0;
    #1 rst_n = 1'b0;
    #0.5 rst_n = 1'b1;
    bus.a = 32'h0;
    #0.5;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL reset_a0: got %h want %h", bus.rd, 32'h0);
    end
    bus.a = 32'h4;
    #0.5;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL reset_a4: got %h want %h", bus.rd, 32'h0);
    end
    bus.a = 32'hFC;
    #0.5;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL reset_aFC: got %h want %h", bus.rd, 32'h0);
    end
    tick();
  endtask

  task automatic test_write_read();
    bus.a  = 32'h4;
    bus.wd = 32'hDEADBEEF;
    bus.we = 1'b1;
    #1;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL rdw_old_word: got %h want %h", bus.rd, 32'h0);
    end
    tick();
    bus.we = 1'b0;
    bus.wd = '0;
    #1;
    total++;
    if (bus.rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_read_a4: got %h want %h", bus.rd, 32'hDEADBEEF);
    end
    tick();
    total++;
    if (bus.rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL hold_a4: got %h want %h", bus.rd, 32'hDEADBEEF);
    end
    bus.a = 32'h0;
    #1;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL neighbour_a0: got %h want %h", bus.rd, 32'h0);
    end
  endtask

  task automatic test_write_disabled();
    bus.a  = 32'h8;
    bus.wd = 32'h12345678;
    bus.we = 1'b0;
    tick();
    tick();
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL we_low_a8: got %h want %h", bus.rd, 32'h0);
    end
  endtask

  task automatic test_alias();
    bus.a  = 32'h10;
    bus.wd = 32'hCAFEF00D;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.wd = '0;
    bus.a  = 32'h13;
    #1;
    total++;
    if (bus.rd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL misaligned_a13: got %h want %h", bus.rd, 32'hCAFEF00D);
    end
    bus.a = 32'h110;
    #1;
    total++;
    if (bus.rd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL alias_a110: got %h want %h", bus.rd, 32'hCAFEF00D);
    end
    bus.a = 32'hFFFF_FF10;
    #1;
    total++;
    if (bus.rd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL alias_high: got %h want %h", bus.rd, 32'hCAFEF00D);
    end
    // Top word of the array, then its alias and the unaffected bottom word.
    bus.a  = 32'hFC;
    bus.wd = 32'h0BADC0DE;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.a  = 32'h1FE;
    #1;
    total++;
    if (bus.rd !== 32'h0BADC0DE) begin
      bad++; $display("FAIL alias_top_word: got %h want %h", bus.rd, 32'h0BADC0DE);
    end
    bus.a = 32'h0;
    #1;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL bottom_untouched: got %h want %h", bus.rd, 32'h0);
    end
  endtask

  task automatic test_reset_priority();
    bus.a  = 32'h4;
    bus.wd = 32'hA5A5A5A5;
    bus.we = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    bus.we = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL rst_prio_a4: got %h want %h", bus.rd, 32'h0);
    end
    bus.a = 32'h10;
    #1;
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL rst_clears_a10: got %h want %h", bus.rd, 32'h0);
    end
    tick();
    total++;
    if (bus.rd !== 32'h0) begin
      bad++; $display("FAIL no_write_after_release: got %h want %h", bus.rd, 32'h0);
    end
    bus.a  = 32'h4;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    #1;
    total++;
    if (bus.rd !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL rewrite_a4: got %h want %h", bus.rd, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_back_to_back();
    bus.a  = 32'h20;
    bus.wd = 32'h11111111;
    bus.we = 1'b1;
    tick();
    total++;
    if (bus.rd !== 32'h11111111) begin
      bad++; $display("FAIL b2b_first: got %h want %h", bus.rd, 32'h11111111);
    end
    bus.wd = 32'h22222222;
    tick();
    bus.we = 1'b0;
    total++;
    if (bus.rd !== 32'h22222222) begin
      bad++; $display("FAIL b2b_second: got %h want %h", bus.rd, 32'h22222222);
    end
    bus.a = 32'h4;
    #1;
    total++;
    if (bus.rd !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL b2b_neighbour: got %h want %h", bus.rd, 32'hA5A5A5A5);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    bus.we = 1'b0;
    bus.a  = '0;
    bus.wd = '0;
    test_reset();
    test_write_read();
    test_write_disabled();
    test_alias();
    test_reset_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_memory
